mc_controller: RTL
==================

# mc_controller

Multicycle control FSM for the MIPS datapath. Sequences one instruction over 3–5 clock cycles, one state per cycle, and drives every datapath select and write enable. Supports RTYPE, LW, SW, BEQ, BNE, ADDI, ORI and J, with the same opcode map and aluop coding as the single-cycle main decoder. Adds a memory-ready handshake, PC-enable generation, an instruction-done pulse and a sticky illegal-opcode trap.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  6  opcode field from the instruction register
- zero  in  1  ALU zero flag
- memready  in  1  unified memory has completed the current access
- pcen  out  1  PC register enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register write enable
- memwrite  out  1  data memory write enable
- regwrite  out  1  register file write enable
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = memory data, 0 = ALUOut
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = sign- or zero-extended immediate, 11 = shifted immediate
- zeroimm  out  1  zero-extend the immediate instead of sign-extending it
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  out  2  00 = add, 01 = sub, 10 = funct, 11 = or
- instr_done  out  1  high in the final cycle of each instruction
- error  out  1  sticky illegal-opcode flag
- state  out  4  current state code, for debug

## Operation
- State codes: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECUTE = 6, ALUWB = 7, BEQEX = 8, BNEEX = 9, IMMEX = 10, IMMWB = 11, JEX = 12, TRAP = 15. Codes 13 and 14 are unused and transition to TRAP.
- All outputs not listed for a state are 0.

States, outputs and transitions:
- FETCH: alusrcb = 01, irwrite = memready, pcwrite = memready.
  - memready = 1 → DECODE; otherwise stay in FETCH.
- DECODE: alusrcb = 11.
  - op 100011 or 101011 → MEMADR
  - op 000000 → EXECUTE
  - op 000100 → BEQEX
  - op 000101 → BNEEX
  - op 001000 or 001101 → IMMEX
  - op 000010 → JEX
  - any other op → TRAP
- MEMADR: alusrca = 1, alusrcb = 10.
  - LW → MEMRD; SW → MEMWR.
- MEMRD: iord = 1.
  - memready = 1 → MEMWB; otherwise stay.
- MEMWB: memtoreg = 1, regwrite = 1 → FETCH.
- MEMWR: iord = 1, memwrite = 1 (held until memready).
  - memready = 1 → FETCH; otherwise stay.
- EXECUTE: alusrca = 1, aluop = 10 → ALUWB.
- ALUWB: regdst = 1, regwrite = 1 → FETCH.
- BEQEX: alusrca = 1, aluop = 01, pcsrc = 01, branch = 1 → FETCH.
- BNEEX: same as BEQEX but with bne = 1 instead of branch = 1 → FETCH.
- IMMEX: alusrca = 1, alusrcb = 10.
  - ADDI: aluop = 00.
  - ORI: aluop = 11, zeroimm = 1.
  - → IMMWB.
- IMMWB: regwrite = 1 → FETCH.
- JEX: pcsrc = 10, pcwrite = 1 → FETCH.
- TRAP: all write enables 0; stays in TRAP until reset.

Derived outputs:
- pcen = pcwrite | (branch & zero) | (bne & ~zero). pcwrite, branch and bne are internal signals.
- op is latched in a 6-bit register on the DECODE cycle. MEMADR and IMMEX decode from this latched copy, not from the live op input.
- instr_done = 1 in:
  - MEMWB, ALUWB, BEQEX, BNEEX, IMMWB, JEX;
  - MEMWR in the cycle memready = 1.
- error: registered; set to 1 on entry to TRAP. Cleared only by reset.

## Timing
- Reset values: state = FETCH, latched op = 0, error = 0.
- While reset = 1, all of pcen, irwrite, memwrite and regwrite are forced to 0, regardless of memready.
- Reset asserted mid-instruction aborts it immediately. No write enable may glitch high during the reset assertion.
- After reset deasserts, fetch begins on the next edge that sees memready = 1.
- Cycle counts with memready constantly 1:
  - 3 cycles: BEQ, BNE, J
  - 4 cycles: RTYPE, SW, ADDI, ORI
  - 5 cycles: LW
- Each low-memready cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- memwrite stays high for every cycle spent in MEMWR, so a write lasts 1 + N cycles for N stall cycles.
- Outputs are Moore-style (decoded from state), except:
  - pcen depends on zero;
  - FETCH irwrite/pcwrite depend on memready;
  - MEMWR instr_done depends on memready.

## Test plan
- Reset, then memready = 1 with RTYPE op 000000:
  - state sequence 0, 1, 6, 7, 0;
  - regdst = regwrite = 1 in ALUWB;
  - instr_done high exactly once.
- LW with memready low for 2 cycles in MEMRD:
  - sequence 0, 1, 2, 3, 3, 3, 4, 0 (7 cycles);
  - memtoreg = regwrite = 1 only in MEMWB.
- BEQ with zero = 1 → pcen = 1 in BEQEX. BEQ with zero = 0 → pcen = 0. BNE mirrors both cases.
- ORI (001101):
  - IMMEX shows aluop = 11, zeroimm = 1, alusrcb = 10;
  - ADDI (001000) shows aluop = 00, zeroimm = 0.
- Opcode 111111 in DECODE:
  - state goes to 15 and error = 1;
  - all write enables stay 0 for 20 cycles;
  - reset clears error to 0 and returns state to 0.
- Reset asserted asynchronously mid-SW while in MEMWR:
  - memwrite drops without waiting for a clock edge;
  - state = 0; error is unchanged at 0.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with memory handshake, PC enable, done pulse and sticky trap.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroimm,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       instr_done,
  output logic       error,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7, BEQEX = 4'd8, BNEEX = 4'd9,
    IMMEX = 4'd10, IMMWB = 4'd11, JEX = 4'd12, TRAP = 4'd15
  } state_t;
  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       error_q;
  logic       pcwrite, branch, bne, irw, mw, rw;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= op;
      error_q <= error_q | (state_d == TRAP);
    end
  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    irw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroimm    = 1'b0;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irw     = memready;
        pcwrite = memready;
        state_d = memready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = EXECUTE;
          6'b000100:            state_d = BEQEX;
          6'b000101:            state_d = BNEEX;
          6'b001000, 6'b001101: state_d = IMMEX;
          6'b000010:            state_d = JEX;
          default:              state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op_q == 6'b101011) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        rw         = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        iord       = 1'b1;
        mw         = 1'b1;
        instr_done = memready;
        state_d    = memready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        rw         = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BEQEX, BNEEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = (state_q == BEQEX);
        bne        = (state_q == BNEEX);
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zeroimm = (op_q == 6'b001101);
        aluop   = zeroimm ? 2'b11 : 2'b00;
        state_d = IMMWB;
      end
      IMMWB: begin
        rw         = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = TRAP;
    endcase
  end
  // Gating by reset keeps FETCH's memready-driven enables low while reset is held.
  assign pcen     = ~reset & (pcwrite | (branch & zero) | (bne & ~zero));
  assign irwrite  = ~reset & irw;
  assign memwrite = ~reset & mw;
  assign regwrite = ~reset & rw;
  assign error    = error_q;
  assign state    = state_q;
endmodule
